// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter: loader-only BOOT phase, then fetch-priority RUN with loader anti-starvation.
// Optional IMEM_ALIGN_CHECK_EN: misaligned fetches return NOP (flagged), misaligned loader writes are dropped.
//
// state | meaning
// ------+--------------------------------------------------------------
// BOOT  | core held (stall), memory owned by the loader
// RUN   | fetch has priority, loader served when idle or when starved
module imem_arbiter #(
    parameter int          ADDR_W     = 20,
    parameter int          STARVE_MAX = 8,
    parameter logic [31:0] NOP_INSTR  = 32'h00000013
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_fetch_req,
    input  logic [31:0]       i_fetch_adr,
    output logic              o_fetch_gnt,
    output logic              o_fetch_valid,
    output logic [31:0]       o_fetch_instr,
    output logic              o_stall,
    input  logic              i_ld_valid,
    input  logic [31:0]       i_ld_adr,
    input  logic [31:0]       i_ld_data,
    output logic              o_ld_ready,
    input  logic              i_ld_done,
    output logic              o_boot_done,
    output logic [ADDR_W-1:0] o_mem_adr,
    output logic              o_mem_we,
    output logic [31:0]       o_mem_wdata,
    input  logic [31:0]       i_mem_rdata
`ifdef IMEM_ALIGN_CHECK_EN
    ,
    output logic              o_fetch_misalign
`endif
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    typedef enum logic {BOOT, RUN} state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] starve_cnt;
    logic             sel_ld;
    logic             ld_aligned;
    logic             fetch_aligned;
    logic             unused_hi;

    // Upper address bits are outside the memory and deliberately ignored.
    assign unused_hi = ^{i_fetch_adr[31:ADDR_W], i_ld_adr[31:ADDR_W]};

`ifdef IMEM_ALIGN_CHECK_EN
    assign ld_aligned    = (i_ld_adr[1:0] == 2'b00);
    assign fetch_aligned = (i_fetch_adr[1:0] == 2'b00);
`else
    assign ld_aligned    = 1'b1;
    assign fetch_aligned = 1'b1;
`endif

    always_comb begin
        state_next  = state;
        o_fetch_gnt = 1'b0;
        o_ld_ready  = 1'b0;
        o_stall     = 1'b0;
        sel_ld      = 1'b0;
        case (state)
            BOOT: begin
                o_ld_ready = 1'b1;
                o_stall    = 1'b1;
                sel_ld     = 1'b1;
                if (i_ld_done) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (i_ld_valid && (starve_cnt == STARVE_LIM)) begin
                    o_ld_ready = 1'b1;
                    sel_ld     = 1'b1;
                    o_stall    = i_fetch_req;
                end else if (i_fetch_req) begin
                    o_fetch_gnt = 1'b1;
                end else begin
                    o_ld_ready = 1'b1;
                    sel_ld     = 1'b1;
                end
            end
            default: state_next = BOOT;
        endcase
    end

    // A misaligned loader word is still handshaken, just never written.
    assign o_mem_we    = sel_ld && i_ld_valid && ld_aligned;
    assign o_mem_adr   = sel_ld ? i_ld_adr[ADDR_W-1:0] : i_fetch_adr[ADDR_W-1:0];
    assign o_mem_wdata = i_ld_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= BOOT;
            o_boot_done <= 1'b0;
        end else begin
            state       <= state_next;
            o_boot_done <= (state_next == RUN);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            starve_cnt <= '0;
        end else if ((state == RUN) && i_ld_valid && !o_ld_ready) begin
            if (starve_cnt != STARVE_LIM) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end else begin
            starve_cnt <= '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_fetch_valid <= 1'b0;
            o_fetch_instr <= NOP_INSTR;
        end else begin
            o_fetch_valid <= o_fetch_gnt;
            if (o_fetch_gnt) begin
                o_fetch_instr <= fetch_aligned ? i_mem_rdata : NOP_INSTR;
            end
        end
    end

`ifdef IMEM_ALIGN_CHECK_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_fetch_misalign <= 1'b0;
        end else begin
            o_fetch_misalign <= o_fetch_gnt && !fetch_aligned;
        end
    end
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: byte-array memory, directed literal checks, then randomized traffic
// compared every cycle against a rule-level model with its own shadow memory.
module tb_imem_arbiter;

    localparam int          ADDR_W = 20;
    localparam int unsigned AMASK  = (32'd1 << ADDR_W) - 1;
    localparam int          SMAX   = 8;
    localparam logic [31:0] NOP    = 32'h00000013;
`ifdef IMEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              fetch_req;
    logic [31:0]       fetch_adr;
    logic              fetch_gnt;
    logic              fetch_valid;
    logic [31:0]       fetch_instr;
    logic              stall;
    logic              ld_valid;
    logic [31:0]       ld_adr;
    logic [31:0]       ld_data;
    logic              ld_ready;
    logic              ld_done;
    logic              boot_done;
    logic [ADDR_W-1:0] mem_adr;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
`ifdef IMEM_ALIGN_CHECK_EN
    logic              fetch_misalign;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    imem_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(SMAX), .NOP_INSTR(NOP)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_fetch_req(fetch_req), .i_fetch_adr(fetch_adr), .o_fetch_gnt(fetch_gnt),
        .o_fetch_valid(fetch_valid), .o_fetch_instr(fetch_instr), .o_stall(stall),
        .i_ld_valid(ld_valid), .i_ld_adr(ld_adr), .i_ld_data(ld_data), .o_ld_ready(ld_ready),
        .i_ld_done(ld_done), .o_boot_done(boot_done),
        .o_mem_adr(mem_adr), .o_mem_we(mem_we), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
`ifdef IMEM_ALIGN_CHECK_EN
        , .o_fetch_misalign(fetch_misalign)
`endif
    );

    // Memory: combinational read, synchronous 4-byte little-endian write, wrapping at 2^ADDR_W
    logic [7:0]        mem [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0] a1, a2, a3;
    assign a1 = mem_adr + ADDR_W'(1);
    assign a2 = mem_adr + ADDR_W'(2);
    assign a3 = mem_adr + ADDR_W'(3);
    assign mem_rdata = {mem[a3], mem[a2], mem[a1], mem[mem_adr]};

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_adr] <= mem_wdata[7:0];
            mem[a1]      <= mem_wdata[15:8];
            mem[a2]      <= mem_wdata[23:16];
            mem[a3]      <= mem_wdata[31:24];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  shadow [int unsigned];
    bit          m_run;
    int          m_wait;
    bit          m_valid;
    logic [31:0] m_instr;
    bit          m_boot;
    bit          m_mis;

    function automatic logic [31:0] sh_word(input logic [31:0] a);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) begin
            int unsigned idx;
            idx = (a + k) & AMASK;
            w[8*k +: 8] = shadow.exists(idx) ? shadow[idx] : 8'h00;
        end
        return w;
    endfunction

    task automatic sh_write(input logic [31:0] a, input logic [31:0] d);
        for (int k = 0; k < 4; k++) begin
            shadow[(a + k) & AMASK] = d[8*k +: 8];
        end
    endtask

    always @(negedge clk) begin
        bit e_gnt, e_ready, e_stall, e_xfer, e_we, ld_ok, f_mis;
        if (!rst_n) begin
            m_run = 0; m_wait = 0; m_valid = 0; m_instr = NOP; m_boot = 0; m_mis = 0;
        end
        ld_ok = !ALIGN || (ld_adr[1:0] == 2'b00);
        f_mis = ALIGN && (fetch_adr[1:0] != 2'b00);
        if (!m_run) begin
            e_gnt = 0; e_ready = 1; e_stall = 1; e_xfer = ld_valid;
        end else if (ld_valid && m_wait == SMAX) begin
            e_gnt = 0; e_ready = 1; e_stall = fetch_req; e_xfer = 1;
        end else if (fetch_req) begin
            e_gnt = 1; e_ready = 0; e_stall = 0; e_xfer = 0;
        end else begin
            e_gnt = 0; e_ready = 1; e_stall = 0; e_xfer = ld_valid;
        end
        e_we = e_xfer && ld_ok;

        chk("fetch_gnt", 32'(fetch_gnt), 32'(e_gnt));
        chk("stall", 32'(stall), 32'(e_stall));
        chk("mem_we", 32'(mem_we), 32'(e_we));
        if (ld_valid || fetch_req) chk("ld_ready", 32'(ld_ready), 32'(e_ready));
        if (e_we) begin
            chk("mem_adr_wr", 32'(mem_adr), ld_adr & AMASK);
            chk("mem_wdata", mem_wdata, ld_data);
        end
        if (e_gnt) chk("mem_adr_rd", 32'(mem_adr), fetch_adr & AMASK);
        chk("fetch_valid", 32'(fetch_valid), 32'(m_valid));
        chk("fetch_instr", fetch_instr, m_instr);
        chk("boot_done", 32'(boot_done), 32'(m_boot));
`ifdef IMEM_ALIGN_CHECK_EN
        chk("fetch_misalign", 32'(fetch_misalign), 32'(m_mis));
`endif

        if (rst_n) begin
            if (e_gnt) begin
                m_valid = 1;
                m_instr = f_mis ? NOP : sh_word(fetch_adr);
                m_mis   = f_mis;
            end else begin
                m_valid = 0;
                m_mis   = 0;
            end
            if (m_run && ld_valid && !e_ready) m_wait = (m_wait < SMAX) ? m_wait + 1 : SMAX;
            else m_wait = 0;
            if (!m_run && ld_done) m_run = 1;
            m_boot = m_run;
        end
        if (e_we) sh_write(ld_adr, ld_data);
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #2;
    endtask

    function automatic logic [31:0] rnd_adr();
        logic [31:0] base;
        case ($urandom_range(0, 7))
            0: base = 32'h0;
            1: base = 32'h10;
            2: base = 32'hFFFFC;
            3: base = 32'hFFFFE;
            4: base = {$urandom_range(0, 15), 2'b00};
            5: base = 32'($urandom_range(0, 63));
            6: base = 32'h20;
            default: base = $urandom & AMASK;
        endcase
        return base | ($urandom & 32'hFFF00000);
    endfunction

    initial begin
        int grants, first;
        bit last_xfer;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'h00;
        rst_n = 0; fetch_req = 0; fetch_adr = 0; ld_valid = 0; ld_adr = 0; ld_data = 0; ld_done = 0;

        repeat (2) cyc();
        mid();
        chk("rst_boot_done", 32'(boot_done), 32'd0);
        chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
        chk("rst_fetch_instr", fetch_instr, 32'h00000013);
        chk("rst_stall", 32'(stall), 32'd1);
        chk("rst_ld_ready", 32'(ld_ready), 32'd1);

        // BOOT: three loader writes, fetch requested but never granted
        cyc(); rst_n = 1; ld_valid = 1; ld_adr = 32'hFFFFE; ld_data = 32'hA1B2C3D4;
        fetch_req = 1; fetch_adr = 0;
        mid(); chk("boot_fetch_gnt", 32'(fetch_gnt), 32'd0);
        cyc(); ld_adr = 32'h0; ld_data = 32'h00500093;
        mid();
        chk("boot_ld_ready", 32'(ld_ready), 32'd1);
        chk("boot_mem_we", 32'(mem_we), 32'd1);
        chk("boot_stall", 32'(stall), 32'd1);
        cyc(); ld_adr = 32'h10; ld_data = 32'h11111111; ld_done = 1;
        mid();
        chk("done_cycle_we", 32'(mem_we), 32'd1);
        chk("done_cycle_boot", 32'(boot_done), 32'd0);
        cyc(); ld_valid = 0; ld_done = 0; fetch_req = 0;
        mid(); chk("boot_done_set", 32'(boot_done), 32'd1);

        // RUN fetches, including the address-wrap word
        cyc(); fetch_req = 1; fetch_adr = 32'h0;
        mid(); chk("run_gnt", 32'(fetch_gnt), 32'd1); chk("run_stall", 32'(stall), 32'd0);
        cyc(); fetch_adr = 32'h10;
        mid(); chk("fetch0_valid", 32'(fetch_valid), 32'd1); chk("fetch0_instr", fetch_instr, 32'h00500093);
        cyc(); fetch_adr = 32'hFFFFE;
        mid(); chk("fetch10_instr", fetch_instr, 32'h11111111);
        cyc(); fetch_req = 0;
        mid(); chk("fetch_wrap_instr", fetch_instr, ALIGN ? 32'h00000013 : 32'h0093C3D4);
`ifdef IMEM_ALIGN_CHECK_EN
        chk("misalign_pulse", 32'(fetch_misalign), 32'd1);
        cyc(); mid(); chk("misalign_clear", 32'(fetch_misalign), 32'd0);
`endif

        // starvation: continuous fetch with a pending loader write
        cyc(); fetch_req = 1; fetch_adr = 32'h0; ld_valid = 1; ld_adr = 32'h20; ld_data = 32'h22222222;
        grants = 0; first = -1;
        for (int i = 0; i < 14; i++) begin
            mid();
            if (ld_valid && ld_ready) begin
                grants++;
                if (first < 0) first = i;
                chk("starve_stall", 32'(stall), 32'd1);
                chk("starve_fetch_gnt", 32'(fetch_gnt), 32'd0);
            end
            cyc();
            if (grants > 0) ld_valid = 0;
        end
        chk("starve_grants", 32'(grants), 32'd1);
        chk("starve_first", 32'(first), 32'd8);

        // read-after-write
        fetch_req = 0; ld_valid = 1; ld_adr = 32'h10; ld_data = 32'hDEADBEEF;
        mid(); chk("raw_we", 32'(mem_we), 32'd1);
        cyc(); ld_valid = 0; fetch_req = 1; fetch_adr = 32'h10;
        cyc(); fetch_req = 0;
        mid(); chk("raw_instr", fetch_instr, 32'hDEADBEEF);

        // reset mid-RUN with a pending loader write
        cyc(); fetch_req = 1; fetch_adr = 32'h0; ld_valid = 1; ld_adr = 32'h30; ld_data = 32'h33333333;
        repeat (3) cyc();
        rst_n = 0;
        mid();
        chk("mrst_boot_done", 32'(boot_done), 32'd0);
        chk("mrst_fetch_valid", 32'(fetch_valid), 32'd0);
        chk("mrst_fetch_instr", fetch_instr, 32'h00000013);
        chk("mrst_stall", 32'(stall), 32'd1);
        cyc(); rst_n = 1; ld_valid = 0; fetch_req = 0;

        // randomized traffic, checked every cycle by the model
        last_xfer = 0;
        for (int n = 0; n < 4000; n++) begin
            mid();
            last_xfer = ld_valid && ld_ready;
            cyc();
            if ($urandom_range(0, 399) == 0) begin
                rst_n = 0;
            end else begin
                rst_n = 1;
            end
            fetch_req = ($urandom_range(0, 3) != 0);
            fetch_adr = rnd_adr();
            ld_done   = ($urandom_range(0, 59) == 0);
            if (!(ld_valid && !last_xfer)) begin
                ld_valid = ($urandom_range(0, 1) == 1);
                ld_adr   = rnd_adr();
                ld_data  = $urandom;
            end
        end
        cyc();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
